stopwatch_mmss: RTL and testbench
=================================

// Module: stopwatch_mmss
//
// PURPOSE
// - Downstream consumer of the modulo-k prescaler: counts its one-cycle rollover pulses into a mm:ss stopwatch.
// - BCD digit outputs drive the display stage; start/stop/clear come from the debounced-button stage.
// - Controlled by a 3-state FSM (IDLE/RUN/PAUSE); wrap pulse at 59:59 for cascading an hours stage.
//
// PARAMETERS
// - TICKS_PER_SEC  default 100  tick pulses per second; legal 1..65535.
// - MIN_MOD        default 60   minutes modulus, 2..99; minutes wrap after MIN_MOD-1.
//
// PORTS
// - clk          in   1   single clock, rising edge.
// - aclr         in   1   synchronous active-low reset, sampled on posedge clk; all state cleared.
// - tick         in   1   one-cycle pulse from prescaler rollover; 1 tick = 1/TICKS_PER_SEC s.
// - start_stop   in   1   one-cycle pulse (debounced upstream); toggles run/pause.
// - clear        in   1   one-cycle pulse; returns to IDLE, zeroes time.
// - sec_ones     out  4   BCD 0..9.
// - sec_tens     out  4   BCD 0..5.
// - min_ones     out  4   BCD 0..9.
// - min_tens     out  4   BCD 0..(MIN_MOD-1)/10.
// - running      out  1   1 while FSM is in RUN.
// - wrap         out  1   one-cycle pulse when time goes (MIN_MOD-1):59 -> 00:00.
//
// BEHAVIOUR
// - Reset (aclr=0 at posedge): state=IDLE, subsec=0, all digits 0, running=0, wrap=0.
// - subsec counter: width clogb2(TICKS_PER_SEC-1) (min 1); counts 0..TICKS_PER_SEC-1.
// - FSM: IDLE --start_stop--> RUN; RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN.
// - clear in any state -> IDLE, subsec and digits zeroed next cycle; clear beats start_stop and tick.
// - Counting only in RUN: tick with subsec<TPS-1 -> subsec+1; at TPS-1 -> subsec=0, seconds+1.
// - Seconds ones 9->0 carries to tens; tens 5 & ones 9 -> 00, carry to minutes.
// - Minutes BCD; at MIN_MOD-1 with seconds carry -> 00, wrap=1 for exactly that cycle.
// - All outputs registered: tick at edge n -> digits/wrap visible after edge n+1 (1-cycle latency).
// - tick in the same cycle as the start_stop that enters RUN: ignored (FSM still in IDLE/PAUSE).
// - tick in the same cycle as the start_stop that leaves RUN: counted (FSM still in RUN).
// - PAUSE holds subsec and digits exactly; resume continues mid-second with no loss.
// - tick while not RUN: dropped, no effect. running = (state==RUN), registered.
// - aclr low mid-count overrides everything; counting restarts from 00:00 in IDLE.
//
// CONFIGURATION
// - Macro STOPWATCH_LAP_HOLD_EN adds input lap (1, one-cycle pulse).
// - With macro: lap in RUN toggles a hold flag. While held, digit outputs freeze at the value
//   captured on the lap cycle; internal count continues. Second lap releases; outputs show live
//   value next cycle. clear or reset drops hold. wrap is never frozen.
// - Without macro: no lap port; digit outputs always show the live count.
//
// STRUCTURE
// - Package stopwatch_pkg: state enum {IDLE, RUN, PAUSE} (2-bit), BCD_W=4 localparam, clogb2 function.
// - Sub-module bcd_digit_counter #(MOD): 4-bit BCD digit, inputs clk, aclr, clr, inc;
//   outputs digit, carry (inc & digit==MOD-1); instanced for sec_ones (10), sec_tens (6), min_ones (10).
// - min_tens plus the MIN_MOD wrap compare live in the top level (two-digit terminal count).
//
// TESTING
// - Reset: hold aclr=0 3 cycles with tick=1, start_stop pulsing -> all digits 0, running=0, wrap=0.
// - TPS=4: start, 4 ticks -> sec_ones=1 one cycle after 4th tick; 40 ticks -> sec_tens=1, sec_ones=0.
// - Pause: TPS=4, run 6 ticks (00:01, subsec=2), pause, 10 ticks -> unchanged.
//   Resume, 2 ticks -> 00:02.
// - Wrap: TPS=1, MIN_MOD=60, 3600 ticks in RUN -> 00:00 with wrap=1 exactly one cycle.
//   MIN_MOD=2: 120 ticks -> wrap.
// - Collisions: clear+start_stop+tick same cycle in RUN at 00:07 -> IDLE, 00:00, running=0.
//   start_stop+tick from IDLE -> RUN, count stays 00:00.
// - STOPWATCH_LAP_HOLD_EN: TPS=1, lap at 00:05, 10 more ticks -> outputs 00:05.
//   Second lap -> 00:15 next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the mm:ss stopwatch.
// State enum, BCD digit width, and a bit-width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int BCD_W = 4;

  // Bits needed to hold value v (never less than 1).
  function automatic int clogb2(input int v);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MOD-1 with carry-out.
// Ports: clk, aclr (sync active-low), clr, inc -> digit, carry.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  localparam logic [BCD_W-1:0] TOP = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  assign carry = inc & (digit_q == TOP);
  assign digit = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = carry ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr) digit_q <= '0;
    else       digit_q <= digit_d;
  end

endmodule

// File: rtl/stopwatch_mmss.sv
// mm:ss stopwatch counting prescaler ticks; IDLE/RUN/PAUSE FSM, wrap pulse.
// Ports: clk, aclr, tick, start_stop, clear [, lap if STOPWATCH_LAP_HOLD_EN] -> BCD digits, running, wrap.
module stopwatch_mmss
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int MIN_MOD       = 60
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic             lap,
`endif
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             wrap
);

  localparam int SUB_W = clogb2(TICKS_PER_SEC - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [BCD_W-1:0] MT_MAX = BCD_W'((MIN_MOD - 1) / 10);
  localparam logic [BCD_W-1:0] MO_MAX = BCD_W'((MIN_MOD - 1) % 10);

  state_e           state_q, state_d;
  logic             running_q;
  logic [SUB_W-1:0] subsec_q, subsec_d;
  logic [BCD_W-1:0] min_tens_q, min_tens_d;
  logic             wrap_q, wrap_d;

  logic             count_en;
  logic             sec_inc;
  logic             so_carry, st_carry, mo_carry;
  logic             mo_clr;
  logic [BCD_W-1:0] so_q, st_q, mo_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counting looks at the current state, so a tick alongside the
  // start_stop entering RUN is dropped and one leaving RUN is kept.
  assign count_en = (state_q == RUN) & tick & ~clear;
  assign sec_inc  = count_en & (subsec_q == SUB_MAX);

  always_comb begin
    subsec_d = subsec_q;
    if (clear) begin
      subsec_d = '0;
    end else if (count_en) begin
      subsec_d = (subsec_q == SUB_MAX) ? '0 : subsec_q + 1'b1;
    end
  end

  bcd_digit_counter #(.MOD(10)) u_sec_ones (
    .clk   (clk),
    .aclr  (aclr),
    .clr   (clear),
    .inc   (sec_inc),
    .digit (so_q),
    .carry (so_carry)
  );

  bcd_digit_counter #(.MOD(6)) u_sec_tens (
    .clk   (clk),
    .aclr  (aclr),
    .clr   (clear),
    .inc   (so_carry),
    .digit (st_q),
    .carry (st_carry)
  );

  // Minutes roll over at MIN_MOD-1, which may not be a ones-digit 9,
  // so the ones digit is force-cleared on wrap.
  assign wrap_d = st_carry & (min_tens_q == MT_MAX) & (mo_q == MO_MAX);
  assign mo_clr = clear | wrap_d;

  bcd_digit_counter #(.MOD(10)) u_min_ones (
    .clk   (clk),
    .aclr  (aclr),
    .clr   (mo_clr),
    .inc   (st_carry),
    .digit (mo_q),
    .carry (mo_carry)
  );

  always_comb begin
    min_tens_d = min_tens_q;
    if (mo_clr) begin
      min_tens_d = '0;
    end else if (mo_carry) begin
      min_tens_d = min_tens_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      subsec_q   <= '0;
      min_tens_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= (state_d == RUN);
      subsec_q   <= subsec_d;
      min_tens_q <= min_tens_d;
      wrap_q     <= wrap_d;
    end
  end

  assign running = running_q;
  assign wrap    = wrap_q;

  logic [4*BCD_W-1:0] live;
  assign live = {min_tens_q, mo_q, st_q, so_q};

`ifdef STOPWATCH_LAP_HOLD_EN
  logic               hold_q, hold_d;
  logic [4*BCD_W-1:0] snap_q, snap_d;

  // Snapshot is taken on the lap that sets hold; count keeps running.
  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap && (state_q == RUN)) begin
      hold_d = ~hold_q;
      if (!hold_q) snap_d = live;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = hold_q ? snap_q : live;
`else
  assign {min_tens, min_ones, sec_tens, sec_ones} = live;
`endif

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Directed self-checking bench for stopwatch_mmss.
// Three instances: TPS=4/MM=60, TPS=1/MM=60, TPS=1/MM=2.
module tb_stopwatch_mmss;

  logic clk = 1'b0;
  logic aclr = 1'b0;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [3:0] so_a, st_a, mo_a, mt_a;
  logic [3:0] so_b, st_b, mo_b, mt_b;
  logic [3:0] so_c, st_c, mo_c, mt_c;
  logic       run_a, run_b, run_c;
  logic       wrap_a, wrap_b, wrap_c;

  wire [15:0] tm_a = {mt_a, mo_a, st_a, so_a};
  wire [15:0] tm_b = {mt_b, mo_b, st_b, so_b};
  wire [15:0] tm_c = {mt_c, mo_c, st_c, so_c};

  stopwatch_mmss #(.TICKS_PER_SEC(4), .MIN_MOD(60)) dut_a (
    .clk(clk), .aclr(aclr), .tick(tick),
    .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so_a), .sec_tens(st_a),
    .min_ones(mo_a), .min_tens(mt_a),
    .running(run_a), .wrap(wrap_a)
  );

  stopwatch_mmss #(.TICKS_PER_SEC(1), .MIN_MOD(60)) dut_b (
    .clk(clk), .aclr(aclr), .tick(tick),
    .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so_b), .sec_tens(st_b),
    .min_ones(mo_b), .min_tens(mt_b),
    .running(run_b), .wrap(wrap_b)
  );

  stopwatch_mmss #(.TICKS_PER_SEC(1), .MIN_MOD(2)) dut_c (
    .clk(clk), .aclr(aclr), .tick(tick),
    .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .sec_ones(so_c), .sec_tens(st_c),
    .min_ones(mo_c), .min_tens(mt_c),
    .running(run_c), .wrap(wrap_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic s,
                     input logic c, input logic l);
    tick = t;
    start_stop = s;
    clear = c;
    lap = l;
    @(posedge clk);
    #1;
    tick = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  int wc_b;
  int wc_c;

  initial begin
    // Reset held 3 cycles with tick and start_stop activity
    aclr = 1'b0;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("rst_time_a", 32'(tm_a), 32'h0);
    chk("rst_time_b", 32'(tm_b), 32'h0);
    chk("rst_time_c", 32'(tm_c), 32'h0);
    chk("rst_run", 32'({run_a, run_b, run_c}), 32'h0);
    chk("rst_wrap", 32'({wrap_a, wrap_b, wrap_c}), 32'h0);
    aclr = 1'b1;
    cyc(0, 0, 0, 0);

    // Basic counting, TPS=4
    cyc(0, 1, 0, 0);
    chk("start_run_a", 32'(run_a), 32'h1);
    ticks(3);
    chk("a_3ticks", 32'(tm_a), 32'h0000);
    ticks(1);
    chk("a_4ticks", 32'(tm_a), 32'h0001);
    chk("b_4ticks", 32'(tm_b), 32'h0004);
    ticks(36);
    chk("a_40ticks", 32'(tm_a), 32'h0010);
    chk("b_40ticks", 32'(tm_b), 32'h0040);
    chk("c_40ticks", 32'(tm_c), 32'h0040);

    // Pause holds subsec and digits
    cyc(0, 0, 1, 0);
    chk("clr_time_a", 32'(tm_a), 32'h0);
    chk("clr_run_a", 32'(run_a), 32'h0);
    cyc(0, 1, 0, 0);
    ticks(6);
    chk("a_6ticks", 32'(tm_a), 32'h0001);
    cyc(0, 1, 0, 0);
    chk("pause_run_a", 32'(run_a), 32'h0);
    ticks(10);
    chk("pause_hold_a", 32'(tm_a), 32'h0001);
    cyc(0, 1, 0, 0);
    chk("resume_run_a", 32'(run_a), 32'h1);
    ticks(1);
    chk("resume_1tick_a", 32'(tm_a), 32'h0001);
    ticks(1);
    chk("resume_2tick_a", 32'(tm_a), 32'h0002);

    // Collisions
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    ticks(7);
    chk("b_007", 32'(tm_b), 32'h0007);
    cyc(1, 1, 1, 0);
    chk("coll_clr_time_b", 32'(tm_b), 32'h0);
    chk("coll_clr_run_b", 32'(run_b), 32'h0);
    cyc(1, 1, 0, 0);
    chk("coll_start_run_b", 32'(run_b), 32'h1);
    chk("coll_start_time_b", 32'(tm_b), 32'h0);
    ticks(1);
    chk("coll_after_b", 32'(tm_b), 32'h0001);

    // Wrap: MIN_MOD=60 over 3600 s, MIN_MOD=2 every 120 s
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    wc_b = 0;
    wc_c = 0;
    for (int i = 1; i <= 3600; i++) begin
      cyc(1, 0, 0, 0);
      if (wrap_b) wc_b++;
      if (wrap_c) wc_c++;
      if (i == 119) begin
        chk("c_0159", 32'(tm_c), 32'h0159);
        chk("c_wrap_pre", 32'(wrap_c), 32'h0);
      end
      if (i == 120) begin
        chk("c_wrap_time", 32'(tm_c), 32'h0000);
        chk("c_wrap", 32'(wrap_c), 32'h1);
      end
      if (i == 121) chk("c_wrap_post", 32'(wrap_c), 32'h0);
      if (i == 3599) begin
        chk("b_5959", 32'(tm_b), 32'h5959);
        chk("b_wrap_pre", 32'(wrap_b), 32'h0);
      end
      if (i == 3600) begin
        chk("b_wrap_time", 32'(tm_b), 32'h0000);
        chk("b_wrap", 32'(wrap_b), 32'h1);
      end
    end
    cyc(0, 0, 0, 0);
    chk("b_wrap_post", 32'(wrap_b), 32'h0);
    chk("b_wrap_count", 32'(wc_b), 32'd1);
    chk("c_wrap_count", 32'(wc_c), 32'd30);

`ifdef STOPWATCH_LAP_HOLD_EN
    // Lap hold freezes the display, count continues
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    ticks(5);
    chk("lap_pre_b", 32'(tm_b), 32'h0005);
    cyc(0, 0, 0, 1);
    ticks(10);
    chk("lap_held_b", 32'(tm_b), 32'h0005);
    cyc(0, 0, 0, 1);
    chk("lap_release_b", 32'(tm_b), 32'h0015);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
